// File: rtl/bcd_7seg_scan_driver.sv
// BCD digit entry buffer with time-multiplexed seven-segment scan output.
// Build option: define SEG_ACTIVE_LOW_EN for inverted seg/an (common-anode displays).
module bcd_7seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        b,
  input  logic                              b_valid,
  output logic                              b_ready,
  input  logic                              clr,
  output logic [6:0]                        seg,
  output logic [NUM_DIGITS-1:0]             an,
  output logic                              err,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   cnt
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_DIGITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic OUT_INV = 1'b1;
`else
  localparam logic OUT_INV = 1'b0;
`endif

  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic [PW-1:0]              psc_q, psc_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [6:0]                 seg_q, seg_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  logic                       full;
  logic                       xfer;
  logic                       blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign full    = (cnt_q == CNT_FULL);
  assign b_ready = ~full & ~clr;
  assign xfer    = b_valid & b_ready;

  always_comb begin
    dig_d = dig_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr) begin
      dig_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (xfer) begin
      if (b <= 4'd9) begin
        dig_d = {dig_q[NUM_DIGITS-2:0], b};
        cnt_d = cnt_q + CW'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    psc_d = psc_q + PW'(1);
    idx_d = idx_q;
    if (psc_q == PSC_LAST) begin
      psc_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Positions at or above the loaded count are blank; digits fill from position 0 up.
  always_comb begin
    blank = (CW'(idx_q) >= cnt_q);
    an_d  = {NUM_DIGITS{OUT_INV}} ^ (NUM_DIGITS'(1) << idx_q);
    seg_d = {7{OUT_INV}} ^ (blank ? 7'h00 : seg_decode(dig_q[idx_q]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      psc_q <= '0;
      idx_q <= '0;
      seg_q <= {7{OUT_INV}};
      an_q  <= {NUM_DIGITS{OUT_INV}};
    end else begin
      dig_q <= dig_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      psc_q <= psc_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;
  assign cnt = cnt_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Scoreboard bench for bcd_7seg_scan_driver: entry, full, error, clear and scan timing.
module tb_bcd_7seg_scan_driver;
  localparam int N   = 4;
  localparam int DIV = 16;

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] b = 4'd0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic       clr = 1'b0;
  logic [6:0] seg;
  logic [N-1:0] an;
  logic       err;
  logic [2:0] cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int m_dig[N];
  int m_cnt = 0;
  bit m_err = 1'b0;

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   seg;
  } exp_t;
  exp_t sb[$];

  bcd_7seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .b(b), .b_valid(b_valid), .b_ready(b_ready),
    .clr(clr), .seg(seg), .an(an), .err(err), .cnt(cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic exp_t exp_for(input int k);
    exp_t e;
    e.an  = {N{INV}} ^ (N'(1) << k);
    e.seg = {7{INV}} ^ ((k < m_cnt) ? seg_of(m_dig[k]) : 7'h00);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_dig[i] = 0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // Called at a negedge; returns at the following negedge with the model updated.
  task automatic send(input logic [3:0] d);
    bit exp_rdy;
    b = d;
    b_valid = 1'b1;
    exp_rdy = (m_cnt < N) && !clr;
    #1;
    n_checks++;
    if (b_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL send_ready d=%0d got=%b exp=%b", d, b_ready, exp_rdy);
    end
    @(negedge clk);
    if (exp_rdy) begin
      if (d <= 9) begin
        for (int i = N - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
        m_dig[0] = int'(d);
        m_cnt++;
      end else begin
        m_err = 1'b1;
      end
    end
    n_checks++;
    if (cnt !== 3'(m_cnt) || err !== m_err) begin
      n_fail++;
      $display("FAIL send_state d=%0d cnt=%0d err=%b exp cnt=%0d err=%b", d, cnt, err, m_cnt, m_err);
    end
  endtask

  task automatic idle();
    b_valid = 1'b0;
    b = 4'd0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
  endtask

  // Checks one full scan pass (plus wrap) against the model. If from_reset,
  // the current sample is the first one after reset release.
  task automatic test_scan(input string tag, input bit from_reset);
    exp_t e;
    exp_t first;
    logic [N-1:0] prev;
    int len;
    bit found;
    first = exp_for(0);
    if (!from_reset) begin
      found = 1'b0;
      prev = an;
      for (int t = 0; t < 4 * N * DIV; t++) begin
        @(negedge clk);
        if (an === first.an && prev !== first.an) begin
          found = 1'b1;
          break;
        end
        prev = an;
      end
      n_checks++;
      if (!found) begin
        n_fail++;
        $display("FAIL %s scan_sync timeout an=%b", tag, an);
        return;
      end
    end
    for (int k = 0; k <= N; k++) sb.push_back(exp_for(k % N));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (an !== e.an || seg !== e.seg) begin
        n_fail++;
        $display("FAIL %s scan_value an=%b seg=%h exp an=%b seg=%h", tag, an, seg, e.an, e.seg);
      end
      if (sb.size() == 0) break;
      len = 1;
      for (int t = 0; t < 4 * DIV; t++) begin
        @(negedge clk);
        if (an !== e.an) break;
        len++;
      end
      n_checks++;
      if (len != DIV) begin
        n_fail++;
        $display("FAIL %s scan_len an=%b got=%0d exp=%0d", tag, e.an, len, DIV);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (seg !== {7{INV}} || an !== {N{INV}}) begin
        n_fail++;
        $display("FAIL reset_hold seg=%h an=%b", seg, an);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (an !== ({N{INV}} ^ N'(1)) || seg !== {7{INV}} || cnt !== 3'd0 || err !== 1'b0 || b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release an=%b seg=%h cnt=%0d err=%b rdy=%b", an, seg, cnt, err, b_ready);
    end
  endtask

  task automatic test_back_to_back();
    send(4'd3);
    send(4'd5);
    send(4'd9);
    idle();
    test_scan("b2b", 1'b0);
  endtask

  task automatic test_full();
    do_clear();
    send(4'd1);
    send(4'd2);
    send(4'd3);
    send(4'd4);
    b = 4'd7;
    b_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++;
      if (b_ready !== 1'b0 || cnt !== 3'd4) begin
        n_fail++;
        $display("FAIL full_hold cyc=%0d rdy=%b cnt=%0d exp rdy=0 cnt=4", i, b_ready, cnt);
      end
      @(negedge clk);
    end
    idle();
    test_scan("full", 1'b0);
  endtask

  task automatic test_error();
    do_clear();
    send(4'd8);
    send(4'hC);
    send(4'd2);
    send(4'd6);
    send(4'd0);
    idle();
    n_checks++;
    if (err !== 1'b1 || cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL err_sticky err=%b cnt=%0d exp err=1 cnt=4", err, cnt);
    end
    test_scan("err", 1'b0);
  endtask

  task automatic test_clear();
    clr = 1'b1;
    b = 4'd1;
    b_valid = 1'b1;
    #1;
    n_checks++;
    if (b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ready got=%b exp=0", b_ready);
    end
    @(negedge clk);
    model_reset();
    n_checks++;
    if (cnt !== 3'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_state cnt=%0d err=%b exp cnt=0 err=0", cnt, err);
    end
    clr = 1'b0;
    idle();
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_release_ready got=%b exp=1", b_ready);
    end
    test_scan("clr", 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    bit found;
    send(4'd7);
    send(4'd5);
    send(4'd6);
    idle();
    test_scan("pre_rst", 1'b0);
    found = 1'b0;
    for (int t = 0; t < 4 * N * DIV; t++) begin
      @(negedge clk);
      if (an === ({N{INV}} ^ N'(4))) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_mid_sync timeout an=%b", an);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (seg !== {7{INV}} || an !== {N{INV}}) begin
      n_fail++;
      $display("FAIL rst_mid_async seg=%h an=%b", seg, an);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cnt !== 3'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state cnt=%0d err=%b", cnt, err);
    end
    test_scan("rst_mid", 1'b1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_back_to_back();
    test_full();
    test_error();
    test_clear();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
